// File: rtl/std_rr_select_arbiter_if.sv
// ============================================================================
// std_rr_select_arbiter_if : request/grant bundle between the round-robin
//   arbiter (master) and its requesters/consumer (slave).  Rev 1.0
// ============================================================================
`default_nettype none

interface std_rr_select_arbiter_if #(
  parameter int ENTRIES      = 2,
  parameter int KIND         = 0,
  parameter int INDEX_WIDTH  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  parameter int SELECT_WIDTH = (KIND == 1) ? ENTRIES : INDEX_WIDTH
) ();

  logic                    clear;
  logic [ENTRIES-1:0]      request;
  logic                    ack;
  logic                    valid;
  logic [ENTRIES-1:0]      grant;
  logic [INDEX_WIDTH-1:0]  index;
  logic [SELECT_WIDTH-1:0] select;

  modport master (
    input  clear, request, ack,
    output valid, grant, index, select
  );

  modport slave (
    output clear, request, ack,
    input  valid, grant, index, select
  );

endinterface

`default_nettype wire

// File: rtl/std_rr_select_arbiter.sv
// ============================================================================
// std_rr_select_arbiter : locking round-robin arbiter producing a BINARY (0)
//   or ONEHOT (1) select for the std demux/mux selectors.  Rev 1.0
// ============================================================================
`default_nettype none

module std_rr_select_arbiter #(
  parameter int ENTRIES      = 2,
  parameter int KIND         = 0,
  parameter int INDEX_WIDTH  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
  parameter int SELECT_WIDTH = (KIND == 1) ? ENTRIES : INDEX_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  std_rr_select_arbiter_if.master      bus
);

  localparam int                     KIND_ONEHOT = 1;
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX  = INDEX_WIDTH'(ENTRIES - 1);
  localparam logic [ENTRIES-1:0]     ONE_HOT_0   = ENTRIES'(1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_GRANTED = 1'b1
  } state_t;

  state_t                  r_state;
  logic [INDEX_WIDTH-1:0]  r_ptr;
  logic [INDEX_WIDTH-1:0]  r_index;
  logic [ENTRIES-1:0]      r_grant;

  logic [INDEX_WIDTH:0]    w_first;
  logic [INDEX_WIDTH:0]    w_rotate;
  logic [INDEX_WIDTH-1:0]  w_next_ptr;
  logic                    w_held;

  // Returns {found, index} of the first set bit scanning start, start+1, ...
  // with wrap; iterating from the far end lets the closest hit overwrite.
  function automatic logic [INDEX_WIDTH:0] find_first(
    input logic [ENTRIES-1:0]     req,
    input logic [INDEX_WIDTH-1:0] start
  );
    logic [INDEX_WIDTH:0] result;
    logic [ENTRIES-1:0]   shifted;
    int                   pos;
    result = '0;
    for (int off = ENTRIES - 1; off >= 0; off--) begin
      pos = int'(start) + off;
      if (pos >= ENTRIES) pos = pos - ENTRIES;
      shifted = req >> pos;
      if (shifted[0]) result = {1'b1, pos[INDEX_WIDTH-1:0]};
    end
    return result;
  endfunction

  always_comb begin
    w_first    = find_first(bus.request, r_ptr);
    w_next_ptr = (r_index == LAST_INDEX) ? '0 : r_index + INDEX_WIDTH'(1);
    w_rotate   = find_first(bus.request & ~r_grant, w_next_ptr);
    w_held     = |(bus.request & r_grant);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_index <= '0;
      r_grant <= '0;
    end else if (bus.clear) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_index <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.request) begin
            r_state <= S_GRANTED;
            r_index <= w_first[INDEX_WIDTH-1:0];
            r_grant <= ONE_HOT_0 << w_first[INDEX_WIDTH-1:0];
          end
        end
        S_GRANTED: begin
          if (bus.ack) begin
            r_ptr <= w_next_ptr;
            if (w_rotate[INDEX_WIDTH]) begin
              r_index <= w_rotate[INDEX_WIDTH-1:0];
              r_grant <= ONE_HOT_0 << w_rotate[INDEX_WIDTH-1:0];
            end else if (!w_held) begin
              r_state <= S_IDLE;
              r_index <= '0;
              r_grant <= '0;
            end
            // else: only the current holder still requests, so it keeps the grant
          end else if (!w_held) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_index <= '0;
          r_grant <= '0;
        end
      endcase
    end
  end

  assign bus.valid = (r_state == S_GRANTED);
  assign bus.grant = r_grant;
  assign bus.index = r_index;

  generate
    if (KIND == KIND_ONEHOT) begin : g_onehot
      assign bus.select = r_grant;
    end else begin : g_binary
      assign bus.select = SELECT_WIDTH'(r_index);
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_std_rr_select_arbiter.sv
// ============================================================================
// tb_std_rr_select_arbiter : directed + random checks of a 4-entry BINARY and a
//   3-entry ONEHOT arbiter against a queue-free behavioural model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_std_rr_select_arbiter;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  std_rr_select_arbiter_if #(.ENTRIES(4), .KIND(0)) bus_a ();
  std_rr_select_arbiter_if #(.ENTRIES(3), .KIND(1)) bus_b ();

  std_rr_select_arbiter #(.ENTRIES(4), .KIND(0)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.master)
  );

  std_rr_select_arbiter #(.ENTRIES(3), .KIND(1)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.master)
  );

  int errors = 0;
  int checks = 0;

  logic [3:0] ra;
  logic       aa;
  logic       ca;
  logic [2:0] rb;
  logic       ab;
  logic       cb;

  bit m_valid [2];
  int m_g     [2];
  int m_ptr   [2];
  int ents    [2] = '{4, 3};

  function automatic bit has_bit(logic [3:0] req, int i);
    logic [3:0] s;
    s = req >> i;
    return s[0];
  endfunction

  // First requester at or after p, walking the ring of n entries.
  function automatic int pick(int n, logic [3:0] req, int p);
    int c;
    for (int off = 0; off < n; off++) begin
      c = (p + off) % n;
      if (has_bit(req, c)) return c;
    end
    return -1;
  endfunction

  task automatic model_step(int d, logic [3:0] req, bit ack, bit clr);
    int w;
    if (clr) begin
      m_valid[d] = 0; m_g[d] = 0; m_ptr[d] = 0;
    end else if (!m_valid[d]) begin
      if (req != 4'd0) begin
        m_valid[d] = 1;
        m_g[d]     = pick(ents[d], req, m_ptr[d]);
      end
    end else if (ack) begin
      m_ptr[d] = (m_g[d] + 1) % ents[d];
      w = pick(ents[d], req & ~(4'd1 << m_g[d]), m_ptr[d]);
      if (w >= 0) m_g[d] = w;
      else if (!has_bit(req, m_g[d])) begin
        m_valid[d] = 0; m_g[d] = 0;
      end
    end else if (!has_bit(req, m_g[d])) begin
      m_valid[d] = 0; m_g[d] = 0;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] eg;
    eg = m_valid[0] ? (32'd1 << m_g[0]) : 32'd0;
    chk("a_valid",  32'(bus_a.valid),  32'(m_valid[0]));
    chk("a_grant",  32'(bus_a.grant),  eg);
    chk("a_index",  32'(bus_a.index),  m_valid[0] ? 32'(m_g[0]) : 32'd0);
    chk("a_select", 32'(bus_a.select), m_valid[0] ? 32'(m_g[0]) : 32'd0);
    eg = m_valid[1] ? (32'd1 << m_g[1]) : 32'd0;
    chk("b_valid",  32'(bus_b.valid),  32'(m_valid[1]));
    chk("b_grant",  32'(bus_b.grant),  eg);
    chk("b_index",  32'(bus_b.index),  m_valid[1] ? 32'(m_g[1]) : 32'd0);
    chk("b_select", 32'(bus_b.select), eg);
  endtask

  task automatic tick();
    @(negedge clk);
    bus_a.request = ra; bus_a.ack = aa; bus_a.clear = ca;
    bus_b.request = rb; bus_b.ack = ab; bus_b.clear = cb;
    @(posedge clk);
    model_step(0, ra, aa, ca);
    model_step(1, 4'(rb), ab, cb);
    #1;
    check_all();
  endtask

  initial begin
    ra = '0; aa = 0; ca = 0; rb = '0; ab = 0; cb = 0;
    bus_a.request = '0; bus_a.ack = 0; bus_a.clear = 0;
    bus_b.request = '0; bus_b.ack = 0; bus_b.clear = 0;
    for (int d = 0; d < 2; d++) begin m_valid[d] = 0; m_g[d] = 0; m_ptr[d] = 0; end
    rst_a = 1; rst_b = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 0; rst_b = 0;
    #1;
    check_all();
    chk("reset_a_grant", 32'(bus_a.grant), 32'd0);

    // First grant lands one edge after the request
    ra = 4'b1010;
    tick();
    chk("t1_grant",  32'(bus_a.grant),  32'h2);
    chk("t1_index",  32'(bus_a.index),  32'd1);
    chk("t1_select", 32'(bus_a.select), 32'd1);

    // Lock: requester 3 waits while 1 holds without ack
    repeat (5) begin
      tick();
      chk("t3_hold", 32'(bus_a.grant), 32'h2);
    end
    aa = 1;
    tick();
    chk("t3_next", 32'(bus_a.grant), 32'h8);

    // Move the grant to 2, then withdraw it
    aa = 0; ra = 4'b1000; tick();
    aa = 1; ra = 4'b0100; tick();
    chk("t4_grant2", 32'(bus_a.grant), 32'h4);
    aa = 0; ra = 4'b0000; tick();
    chk("t4_withdraw", 32'(bus_a.valid), 32'd0);
    ra = 4'b1100; tick();
    chk("t4_regrant", 32'(bus_a.grant), 32'h4);

    // Clear wins over a simultaneous ack
    aa = 1; ra = 4'b1000; tick();
    chk("t5_grant3", 32'(bus_a.grant), 32'h8);
    ca = 1; ra = 4'b1001; tick();
    chk("t5_clear", 32'(bus_a.valid), 32'd0);
    ca = 0; aa = 0; tick();
    chk("t5_after", 32'(bus_a.grant), 32'h1);

    // Fairness: all requesting, ack every cycle
    ca = 1; ra = 4'b0000; tick();
    ca = 0; ra = 4'b1111; tick();
    chk("t2_first", 32'(bus_a.index), 32'd0);
    aa = 1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t2_order", 32'(bus_a.index), 32'(k % 4));
      chk("t2_nogap", 32'(bus_a.valid), 32'd1);
    end
    aa = 0; ra = 4'b0000; tick();

    // 3-entry ONEHOT rotation
    rb = 3'b111; tick();
    chk("t6_first", 32'(bus_b.select), 32'h1);
    ab = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t6_rot", 32'(bus_b.select), 32'd1 << (k % 3));
    end
    ab = 0; tick();

    // Asynchronous reset pulse between edges
    #2;
    rst_b = 1;
    #1;
    chk("t6_async_valid", 32'(bus_b.valid),  32'd0);
    chk("t6_async_grant", 32'(bus_b.grant),  32'd0);
    chk("t6_async_sel",   32'(bus_b.select), 32'd0);
    rst_b = 0;
    m_valid[1] = 0; m_g[1] = 0; m_ptr[1] = 0;
    tick();
    chk("t6_after_rst", 32'(bus_b.grant), 32'h1);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 1) == 0) ra = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) rb = 3'($urandom_range(0, 7));
      aa = ($urandom_range(0, 2) == 0);
      ab = ($urandom_range(0, 2) == 0);
      ca = ($urandom_range(0, 31) == 0);
      cb = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
